dmem_resp: RTL and testbench
============================

Name: dmem_resp

Overview:
Multi-cycle data-memory responder: the slave end of the CPU load/store interface. Accepts one request at a time (address, read/write, access size, store data) and runs a wait-state counter. It then performs the word/half/byte access on an internal word array and returns extended load data with a one-cycle ready pulse. Misaligned, out-of-range and reserved-op requests are answered with a fault response instead of an access.

Parameters:
ADDR_WIDTH, 10, log2 of the number of 32-bit words in the array (1024 words).
WAIT_STATES, 2, cycles spent in WAIT between accept and response (0 allowed).

Ports:
clk  input  1  clock; all state changes on rising edge
rest  input  1  asynchronous active-high reset
req  input  1  request strobe; sampled only while busy=0
we  input  1  1 = store, 0 = load; sampled with req
op  input  3  access size: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned, 101-111 reserved
addr  input  32  byte address; sampled with req
wdata  input  32  store data, low bits used for half/byte; sampled with req
busy  output  1  1 while a request is in WAIT or RESP
ready  output  1  one-cycle pulse: response valid
fault  output  1  valid with ready: request rejected, no access done
rdata  output  32  load result, valid with ready

Behaviour:
- Reset (rest=1, async): state=IDLE; busy=0, ready=0, fault=0, rdata=0, wait counter=0. The memory array is not cleared. Reset mid-request abandons it; a pending store is not performed.
- States: IDLE, WAIT, RESP. Registered outputs: busy=1 in WAIT and RESP; ready=1 only in RESP.
- IDLE, req=1 at an edge: latch we/op/addr/wdata and evaluate the fault conditions:
  - reserved op;
  - word with addr[1:0]!=0;
  - half with addr[0]!=0;
  - addr[31:ADDR_WIDTH+2]!=0.
- On a fault: go to RESP with fault=1, rdata=0, no array access, wait states skipped.
- Otherwise: counter=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else perform the access and go to RESP.
- WAIT: counter decrements each cycle. At the edge where counter==1, perform the access and go to RESP.
- Latency (no fault): request accepted at edge N -> ready high in the cycle after edge N+WAIT_STATES.
- Fault latency: ready high in the cycle after edge N.
- RESP: lasts exactly one cycle, then returns to IDLE. req is ignored in WAIT and RESP, so it is not queued. A new request can be accepted at the first edge in IDLE, giving one idle cycle between responses.
- Word index = addr[ADDR_WIDTH+1:2]. Byte order is little-endian: byte lane k = bits [8k+7:8k], selected by addr[1:0].
- Store word: write all 32 bits.
- Store half: write wdata[15:0] into lanes {1,0} if addr[1]=0, else lanes {3,2}.
- Store byte: write wdata[7:0] into lane addr[1:0]. Other lanes are unchanged.
- Store response: fault=0; rdata holds its previous value.
- Loads: read the selected half/byte, then sign-extend (ops 001, 011) or zero-extend (ops 010, 100) to 32 bits. Word loads return the full word.
- The array is written only on the single access edge, never in WAIT or on a fault.
- Outside RESP: fault=0; rdata holds its last value.

Test Plan:
- Reset, then store word: addr=0x10, wdata=0xDEADBEEF; then load word at 0x10 -> ready after WAIT_STATES+1 cycles, rdata=0xDEADBEEF, fault=0; busy high exactly WAIT_STATES+1 cycles.
- Store byte op=011, addr=0x11, wdata=0x000000AA onto 0xDEADBEEF -> load word at 0x10 = 0xDEADAAEF. Load byte signed at 0x11 -> 0xFFFFFFAA; load byte unsigned at 0x11 -> 0x000000AA.
- Store half addr=0x12, wdata=0x8001 -> load half signed at 0x12 = 0xFFFF8001; load half unsigned at 0x12 = 0x00008001; load word at 0x10 = 0x8001AAEF.
- Fault cases (each -> fault=1, ready in the cycle after accept, rdata=0, memory unchanged):
  - load word at 0x13;
  - store half at 0x11;
  - op=110;
  - addr=0x00001000 with ADDR_WIDTH=10.
- req held high continuously through a load -> exactly one response per IDLE acceptance; no request taken during WAIT/RESP. Repeat with WAIT_STATES=0 -> ready on the cycle after accept.
- Assert rest during WAIT of a store to 0x20 (old value 0x12345678) -> outputs return to 0 immediately; a later load at 0x20 returns 0x12345678.

Source files
------------

// File: rtl/dmem_resp.sv
// dmem_resp: multi-cycle data-memory responder for the CPU load/store interface.
// Ports: clk, rest (async active-high reset); req/we/op/addr/wdata request inputs
// sampled in IDLE; busy (WAIT or RESP), ready (one-cycle response pulse),
// fault (request rejected, valid with ready), rdata (extended load data).
module dmem_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic        fault,
    output logic [31:0] rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic we_q;
    logic [2:0] op_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic req_flt, accept, access, a_we;
    logic [2:0] a_op;
    logic [ADDR_WIDTH+1:0] a_addr;
    logic [31:0] a_wdata, old, mask, merged, ld;
    logic [4:0] sh;
    logic [15:0] lane;
    logic [ADDR_WIDTH-1:0] idx;
    always_comb begin
        req_flt = op > 3'd4 || (op == 3'd0 && addr[1:0] != 2'd0) ||
                  ((op == 3'd1 || op == 3'd2) && addr[0]) || (addr >> (ADDR_WIDTH + 2)) != 32'd0;
        accept = state == IDLE && req;
        // With no wait states the access happens on the accept edge, so it must use the live inputs.
        access = (accept && !req_flt && WAIT_STATES == 0) || (state == WAIT && cnt == CW'(1));
        a_we = state == IDLE ? we : we_q;
        a_op = state == IDLE ? op : op_q;
        a_addr = state == IDLE ? addr[ADDR_WIDTH+1:0] : addr_q;
        a_wdata = state == IDLE ? wdata : wdata_q;
        idx = a_addr[ADDR_WIDTH+1:2];
        old = mem[idx];
        sh = a_op == 3'd0 ? 5'd0 : a_op <= 3'd2 ? {a_addr[1], 4'b0} : {a_addr[1:0], 3'b0};
        mask = a_op == 3'd0 ? 32'hFFFF_FFFF : a_op <= 3'd2 ? 32'h0000_FFFF << sh : 32'h0000_00FF << sh;
        merged = (old & ~mask) | ((a_wdata << sh) & mask);
        lane = 16'(old >> sh);
        ld = a_op == 3'd1 ? {{16{lane[15]}}, lane} :
             a_op == 3'd2 ? {16'b0, lane} :
             a_op == 3'd3 ? {{24{lane[7]}}, lane[7:0]} :
             a_op == 3'd4 ? {24'b0, lane[7:0]} : old;
        state_nx = state == RESP ? IDLE :
                   state == WAIT ? (cnt == CW'(1) ? RESP : WAIT) :
                   !req ? IDLE : (req_flt || WAIT_STATES == 0) ? RESP : WAIT;
    end
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state <= IDLE;
            busy <= 1'b0;
            ready <= 1'b0;
            fault <= 1'b0;
            rdata <= 32'd0;
            cnt <= '0;
            we_q <= 1'b0;
            op_q <= 3'd0;
            addr_q <= '0;
            wdata_q <= 32'd0;
        end else begin
            state <= state_nx;
            busy <= state_nx != IDLE;
            ready <= state_nx == RESP;
            fault <= accept && req_flt;
            if (accept) begin
                we_q <= we;
                op_q <= op;
                addr_q <= addr[ADDR_WIDTH+1:0];
                wdata_q <= wdata;
                cnt <= CW'(WAIT_STATES);
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
            if (accept && req_flt)
                rdata <= 32'd0;
            else if (access && !a_we)
                rdata <= ld;
        end
    end
    // The array has no reset: contents survive rest.
    always_ff @(posedge clk) begin
        if (access && a_we)
            mem[idx] <= merged;
    end
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: randomized self-checking bench for dmem_resp (WAIT_STATES 2 and 0) against a byte-array model.
module tb_dmem_resp;
    logic clk = 1'b0;
    logic rest, req, we, sel;
    logic [2:0] op;
    logic [31:0] addr, wdata;
    logic busy_a, ready_a, fault_a, busy_b, ready_b, fault_b;
    logic [31:0] rdata_a, rdata_b;
    logic req_a, req_b, obs_busy, obs_ready, obs_fault;
    logic [31:0] obs_rdata;
    int n_chk = 0, n_pass = 0;
    logic [7:0] bm [2][0:4095];
    logic [31:0] prev_rd [2];

    always #5 clk = ~clk;
    assign req_a = req & ~sel;
    assign req_b = req & sel;
    assign obs_busy = sel ? busy_b : busy_a;
    assign obs_ready = sel ? ready_b : ready_a;
    assign obs_fault = sel ? fault_b : fault_a;
    assign obs_rdata = sel ? rdata_b : rdata_a;

    dmem_resp #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_a (
        .clk(clk), .rest(rest), .req(req_a), .we(we), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy_a), .ready(ready_a), .fault(fault_a), .rdata(rdata_a));
    dmem_resp #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_b (
        .clk(clk), .rest(rest), .req(req_b), .we(we), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy_b), .ready(ready_b), .fault(fault_b), .rdata(rdata_b));

    function automatic int ws(input logic s);
        return s ? 0 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic model_fault(input logic [2:0] o, input logic [31:0] a);
        return o > 3'd4 || (o == 3'd0 && a % 4 != 0) || ((o == 3'd1 || o == 3'd2) && a % 2 != 0) || a >= 32'd4096;
    endfunction

    function automatic logic [31:0] model_load(input logic s, input logic [2:0] o, input logic [31:0] a);
        int i;
        logic [15:0] h;
        i = int'(a % 4096);
        h = {bm[s][(i + 1) % 4096], bm[s][i]};
        case (o)
            3'd1: return 32'($signed(h));
            3'd2: return {16'd0, h};
            3'd3: return 32'($signed(bm[s][i]));
            3'd4: return {24'd0, bm[s][i]};
            default: return {bm[s][i + 3], bm[s][i + 2], bm[s][i + 1], bm[s][i]};
        endcase
    endfunction

    task automatic model_store(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        int i, n;
        i = int'(a % 4096);
        n = o == 3'd0 ? 4 : o <= 3'd2 ? 2 : 1;
        for (int k = 0; k < n; k++) bm[s][i + k] = 8'(d >> (8 * k));
    endtask

    task automatic txn(input logic s, input logic w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        int lat, bc;
        logic f;
        logic [31:0] exp;
        @(negedge clk);
        sel = s; req = 1'b1; we = w; op = o; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        f = model_fault(o, a);
        exp = f ? 32'd0 : w ? prev_rd[s] : model_load(s, o, a);
        lat = 0; bc = 0;
        forever begin
            @(negedge clk);
            bc += int'(obs_busy);
            if (obs_ready || lat == 20) break;
            lat++;
        end
        check("latency", lat, f ? 0 : ws(s));
        check("busy_cycles", bc, lat + 1);
        check("fault", obs_fault, f);
        check("rdata", obs_rdata, exp);
        @(negedge clk);
        check("idle_after", {obs_busy, obs_ready, obs_fault}, 3'b000);
        if (!f && w) model_store(s, o, a, d);
        prev_rd[s] = exp;
    endtask

    task automatic hold(input logic s, input logic [31:0] a);
        int p, c, pulses, tmo;
        p = ws(s) + 2;
        c = 4 * p;
        pulses = 0;
        @(negedge clk);
        sel = s; req = 1'b1; we = 1'b0; op = 3'd0; addr = a;
        for (int i = 1; i <= c; i++) begin
            @(negedge clk);
            if (obs_ready) begin
                pulses++;
                check("hold_rdata", obs_rdata, model_load(s, 3'd0, a));
            end
        end
        check("hold_pulses", pulses, (c - 1 - ws(s)) / p + 1);
        req = 1'b0;
        tmo = 0;
        while (obs_busy && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        check("hold_drain", obs_busy, 1'b0);
        prev_rd[s] = model_load(s, 3'd0, a);
    endtask

    initial begin
        logic s, w;
        logic [2:0] o;
        logic [31:0] a;
        rest = 1'b1; req = 1'b0; we = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0; sel = 1'b0;
        prev_rd[0] = 32'd0; prev_rd[1] = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_a", {busy_a, ready_a, fault_a}, 3'b000);
        check("rst_a_rdata", rdata_a, 32'd0);
        check("rst_b", {busy_b, ready_b, fault_b}, 3'b000);
        check("rst_b_rdata", rdata_b, 32'd0);
        rest = 1'b0;
        txn(0, 1, 3'd0, 32'h10, 32'hDEADBEEF);
        txn(0, 0, 3'd0, 32'h10, 32'h0);
        txn(0, 1, 3'd3, 32'h11, 32'h000000AA);
        txn(0, 0, 3'd0, 32'h10, 32'h0);
        txn(0, 0, 3'd3, 32'h11, 32'h0);
        txn(0, 0, 3'd4, 32'h11, 32'h0);
        txn(0, 1, 3'd1, 32'h12, 32'h00008001);
        txn(0, 0, 3'd1, 32'h12, 32'h0);
        txn(0, 0, 3'd2, 32'h12, 32'h0);
        txn(0, 0, 3'd0, 32'h10, 32'h0);
        txn(0, 0, 3'd0, 32'h13, 32'h0);
        txn(0, 1, 3'd1, 32'h11, 32'h0000FFFF);
        txn(0, 1, 3'd6, 32'h10, 32'h11111111);
        txn(0, 1, 3'd0, 32'h1000, 32'h22222222);
        txn(0, 0, 3'd0, 32'h10, 32'h0);
        hold(0, 32'h10);
        txn(0, 1, 3'd0, 32'h20, 32'h12345678);
        @(negedge clk);
        sel = 1'b0; req = 1'b1; we = 1'b1; op = 3'd0; addr = 32'h20; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rest = 1'b1;
        #1;
        check("midreset_ctl", {busy_a, ready_a, fault_a}, 3'b000);
        check("midreset_rdata", rdata_a, 32'd0);
        #2 rest = 1'b0;
        prev_rd[0] = 32'd0; prev_rd[1] = 32'd0;
        txn(0, 0, 3'd0, 32'h20, 32'h0);
        for (int i = 0; i < 16; i++) begin
            txn(0, 1, 3'd0, 32'h100 + 4 * i, $urandom);
            txn(1, 1, 3'd0, 32'h100 + 4 * i, $urandom);
        end
        txn(1, 0, 3'd0, 32'h10C, 32'h0);
        hold(1, 32'h104);
        for (int i = 0; i < 150; i++) begin
            s = 1'($urandom);
            w = 1'($urandom);
            o = $urandom_range(0, 7) == 7 ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            a = 32'h100 + $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(12, 31));
            txn(s, w, o, a, $urandom);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
